contador_monitor: RTL and testbench

- Receive-side checker for the up/down counter output stream (q, mode) feeding the verification environment and on-chip debug.
- Samples the count each valid cycle, predicts the next value from the sampled mode, locks once a consistent sequence is seen, then flags and counts deviations.
- Drops to a FAULT state on persistent mismatch. Pure observer; it never drives the counter.

---
 rtl/contador_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_contador_monitor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_monitor.sv
// ---------------------------------------------------------------------------
// contador_monitor
//
// Receive-side checker for an up/down counter output stream. Every valid
// sample is used to predict the next count (+1 when counting up, -1 when
// counting down, 0 after an observed synchronous reset). After LOCK_N
// consecutive correct predictions the monitor locks. While locked, each
// wrong sample produces a one-cycle err pulse and bumps a saturating error
// counter. MAX_MISS consecutive misses drop the monitor into FAULT, and it
// stays there until clr_err or reset. The block only observes and never
// drives the counter.
//
// Optional feature macro: CTR_MON_WRAP_EN
//   When defined, adds wrap (one-cycle pulse on a correct locked sample that
//   crosses the max/0 boundary) and wrap_count (saturating wrap total).
//
// Ports:
//   clk         in   clock, all logic on its rising edge
//   reset       in   asynchronous reset, active low (0 = in reset)
//   valid_in    in   q_in / mode_in / rst_obs hold a sample this cycle
//   q_in        in   observed counter value [WIDTH-1:0]
//   mode_in     in   observed direction, 0 = up, 1 = down
//   rst_obs     in   observed counter synchronous reset for this sample
//   clr_err     in   synchronous clear of err_count, miss count and FAULT
//   locked      out  high while in LOCKED
//   fault       out  high while in FAULT
//   err         out  one-cycle pulse per bad sample while LOCKED
//   err_count   out  saturating mismatch total [ERR_W-1:0]
//   exp_q       out  prediction for the next sample [WIDTH-1:0]
//   wrap        out  (CTR_MON_WRAP_EN only) boundary-crossing pulse
//   wrap_count  out  (CTR_MON_WRAP_EN only) saturating wrap total
// ---------------------------------------------------------------------------
module contador_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_N   = 4,
    parameter int MAX_MISS = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             mode_in,
    input  logic             rst_obs,
    input  logic             clr_err,
    output logic             locked,
    output logic             fault,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] exp_q
`ifdef CTR_MON_WRAP_EN
    ,
    output logic             wrap,
    output logic [ERR_W-1:0] wrap_count
`endif
);

    localparam int MATCH_W = $clog2(LOCK_N + 1);
    localparam int MISS_W  = $clog2(MAX_MISS + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNC     = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_next;
    logic [MISS_W-1:0]  miss_cnt;
    logic [MISS_W-1:0]  miss_next;
    logic               err_inc;
    logic               hit;
    logic [WIDTH-1:0]   pred_q;

    assign hit = (q_in == exp_q);

    // Prediction of the sample that should follow the current one. The
    // arithmetic wraps naturally at the WIDTH boundary, so max->0 and 0->max
    // are ordinary steps rather than errors.
    always_comb begin
        pred_q = '0;
        if (rst_obs) begin
            pred_q = '0;
        end else if (mode_in) begin
            pred_q = q_in - WIDTH'(1);
        end else begin
            pred_q = q_in + WIDTH'(1);
        end
    end

    // Next-state logic. A gap (valid_in low) while syncing or locked throws
    // away the lock. A miss that would reach MAX_MISS is not allowed to enter
    // FAULT when clr_err arrives in the same cycle, because clr_err zeroes
    // the miss count and wins over it.
    always_comb begin
        state_next = state;
        match_next = match_cnt;
        miss_next  = miss_cnt;
        err_inc    = 1'b0;
        case (state)
            UNLOCKED: begin
                if (valid_in) begin
                    state_next = SYNC;
                    match_next = '0;
                end
            end
            SYNC: begin
                if (!valid_in) begin
                    state_next = UNLOCKED;
                    match_next = '0;
                end else if (hit) begin
                    if (match_cnt == MATCH_W'(LOCK_N - 1)) begin
                        state_next = LOCKED;
                        match_next = '0;
                    end else begin
                        match_next = match_cnt + MATCH_W'(1);
                    end
                end else begin
                    match_next = '0;
                end
            end
            LOCKED: begin
                if (!valid_in) begin
                    state_next = UNLOCKED;
                    miss_next  = '0;
                end else if (hit) begin
                    miss_next = '0;
                end else begin
                    err_inc   = 1'b1;
                    miss_next = miss_cnt + MISS_W'(1);
                    if (!clr_err && (miss_cnt == MISS_W'(MAX_MISS - 1))) begin
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_next = UNLOCKED;
                end
            end
            default: begin
                state_next = UNLOCKED;
            end
        endcase
        if (clr_err) begin
            miss_next = '0;
        end
    end

    // State, counters and registered outputs. locked/fault are taken from
    // the next state so they become visible right after the deciding edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= UNLOCKED;
            match_cnt <= '0;
            miss_cnt  <= '0;
            exp_q     <= '0;
            err       <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            match_cnt <= match_next;
            miss_cnt  <= miss_next;
            err       <= err_inc;
            locked    <= (state_next == LOCKED);
            fault     <= (state_next == FAULT);
            if (valid_in) begin
                exp_q <= pred_q;
            end
            if (clr_err) begin
                err_count <= '0;
            end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

`ifdef CTR_MON_WRAP_EN
    logic [WIDTH-1:0] prev_q;
    logic             prev_mode;
    logic             prev_rst;
    logic             wrap_inc;

    // A wrap is a correct locked sample that completes a max->0 step while
    // counting up or a 0->max step while counting down. A step caused by an
    // observed counter reset is not a wrap.
    assign wrap_inc = (state == LOCKED) && valid_in && hit && !prev_rst &&
                      (((q_in == '0) && (prev_q == {WIDTH{1'b1}}) && !prev_mode) ||
                       ((q_in == {WIDTH{1'b1}}) && (prev_q == '0) && prev_mode));

    // Previous-sample history and the wrap outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            prev_mode  <= 1'b0;
            prev_rst   <= 1'b0;
            wrap       <= 1'b0;
            wrap_count <= '0;
        end else begin
            wrap <= wrap_inc;
            if (valid_in) begin
                prev_q    <= q_in;
                prev_mode <= mode_in;
                prev_rst  <= rst_obs;
            end
            if (clr_err) begin
                wrap_count <= '0;
            end else if (wrap_inc && (wrap_count != {ERR_W{1'b1}})) begin
                wrap_count <= wrap_count + ERR_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_contador_monitor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_contador_monitor
//
// Scoreboard bench for contador_monitor. The driver applies one sample per
// clock on the falling edge, advances a behavioural model of the monitor
// and queues the outputs expected after the next rising edge. A separate
// monitor process pops the queue shortly after every rising edge and
// compares. Directed sequences follow the test plan; a randomized counter
// stream with glitches, gaps, direction changes and clears follows.
// ---------------------------------------------------------------------------
module tb_contador_monitor;

    localparam int WIDTH    = 8;
    localparam int LOCK_N   = 4;
    localparam int MAX_MISS = 3;
    localparam int ERR_W    = 16;
    localparam int QMOD     = 1 << WIDTH;
    localparam int CMAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] q_in = '0;
    logic             mode_in = 1'b0;
    logic             rst_obs = 1'b0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic             fault;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] exp_q;
`ifdef CTR_MON_WRAP_EN
    logic             wrap;
    logic [ERR_W-1:0] wrap_count;
`endif

    contador_monitor #(
        .WIDTH(WIDTH), .LOCK_N(LOCK_N), .MAX_MISS(MAX_MISS), .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .q_in(q_in),
        .mode_in(mode_in),
        .rst_obs(rst_obs),
        .clr_err(clr_err),
        .locked(locked),
        .fault(fault),
        .err(err),
        .err_count(err_count),
        .exp_q(exp_q)
`ifdef CTR_MON_WRAP_EN
        ,
        .wrap(wrap),
        .wrap_count(wrap_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit locked;
        bit fault;
        bit err;
        int err_count;
        int exp_q;
        bit wrap;
        int wrap_count;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    // Behavioural model: phase 0 = waiting for a first sample, 1 = building
    // confidence, 2 = locked, 3 = faulted.
    int m_phase;
    int m_exp;
    int m_run;
    int m_miss;
    int m_errs;
    int m_wraps;
    int m_prevq;
    bit m_prevmode;
    bit m_prevrst;
    bit m_errp;
    bit m_wrapp;

    function automatic void modelReset();
        m_phase = 0; m_exp = 0; m_run = 0; m_miss = 0; m_errs = 0;
        m_wraps = 0; m_prevq = 0; m_prevmode = 0; m_prevrst = 0;
        m_errp = 0; m_wrapp = 0;
    endfunction

    function automatic void modelStep(bit v, int q, bit md, bit r, bit c);
        int old  = m_phase;
        bit good = (q == m_exp);
        int nexp = r ? 0 : (md ? (q + QMOD - 1) % QMOD : (q + 1) % QMOD);
        m_errp  = 0;
        m_wrapp = 0;
        if (old == 0) begin
            if (v) begin m_phase = 1; m_run = 0; end
        end else if (old == 1) begin
            if (!v) begin
                m_phase = 0; m_run = 0;
            end else if (good) begin
                m_run++;
                if (m_run == LOCK_N) begin m_phase = 2; m_run = 0; end
            end else begin
                m_run = 0;
            end
        end else if (old == 2) begin
            if (!v) begin
                m_phase = 0; m_miss = 0;
            end else if (good) begin
                m_miss = 0;
                if (!m_prevrst && ((q == 0 && m_prevq == QMOD - 1 && !m_prevmode) ||
                                   (q == QMOD - 1 && m_prevq == 0 && m_prevmode))) begin
                    m_wrapp = 1;
                    if (m_wraps < CMAX) m_wraps++;
                end
            end else begin
                m_errp = 1;
                if (m_errs < CMAX) m_errs++;
                m_miss++;
                if (m_miss >= MAX_MISS) m_phase = 3;
            end
        end
        if (v) begin
            m_exp = nexp; m_prevq = q; m_prevmode = md; m_prevrst = r;
        end
        if (c) begin
            m_errs = 0; m_miss = 0; m_wraps = 0;
            if (old == 3) m_phase = 0;
            if (old == 2 && m_phase == 3) m_phase = 2;
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input int q, input bit md, input bit r, input bit c);
        exp_t e;
        @(negedge clk);
        valid_in = v;
        q_in     = WIDTH'(q);
        mode_in  = md;
        rst_obs  = r;
        clr_err  = c;
        modelStep(v, q, md, r, c);
        e.locked     = (m_phase == 2);
        e.fault      = (m_phase == 3);
        e.err        = m_errp;
        e.err_count  = m_errs;
        e.exp_q      = m_exp;
        e.wrap       = m_wrapp;
        e.wrap_count = m_wraps;
        sb.push_back(e);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, ".locked"}, int'(locked), 0);
        checkOutput({tag, ".fault"}, int'(fault), 0);
        checkOutput({tag, ".err"}, int'(err), 0);
        checkOutput({tag, ".err_count"}, int'(err_count), 0);
        checkOutput({tag, ".exp_q"}, int'(exp_q), 0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation just
    // after every rising edge that has one pending.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("sb.locked", int'(locked), int'(e.locked));
            checkOutput("sb.fault", int'(fault), int'(e.fault));
            checkOutput("sb.err", int'(err), int'(e.err));
            checkOutput("sb.err_count", int'(err_count), e.err_count);
            checkOutput("sb.exp_q", int'(exp_q), e.exp_q);
`ifdef CTR_MON_WRAP_EN
            checkOutput("sb.wrap", int'(wrap), int'(e.wrap));
            checkOutput("sb.wrap_count", int'(wrap_count), e.wrap_count);
`endif
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int cnt;
        bit md;
        bit v;
        bit r;
        bit c;
        int q;
        int burst;

        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkZeroOutputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Up-count lock: 10..14, then locked with prediction 15.
        for (int i = 10; i <= 14; i++) applyStimulus(1, i, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("up.locked", int'(locked), 1);
        checkOutput("up.exp_q", int'(exp_q), 15);
        checkOutput("up.err_count", int'(err_count), 0);

        // Relock on a down-count and cross 0 -> 255 while locked.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 8; i >= 4; i--) applyStimulus(1, i, 1, 0, 0);
        applyStimulus(1, 3, 1, 0, 0);
        applyStimulus(1, 2, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 255, 1, 0, 0);
        @(posedge clk); #2;
        checkOutput("down.locked", int'(locked), 1);
        checkOutput("down.err_count", int'(err_count), 0);

        // Single injected error while locked at 20.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 16; i <= 20; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 25, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("inject.err", int'(err), 1);
        checkOutput("inject.err_count", int'(err_count), 1);
        checkOutput("inject.exp_q", int'(exp_q), 26);
        applyStimulus(1, 26, 0, 0, 0);

        // Clear the count while locked, then three bad samples force FAULT.
        applyStimulus(1, 27, 0, 0, 1);
        for (int i = 28; i <= 30; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 40, 0, 0, 0);
        applyStimulus(1, 50, 0, 0, 0);
        applyStimulus(1, 60, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("fault.err_count", int'(err_count), 3);
        checkOutput("fault.fault", int'(fault), 1);
        checkOutput("fault.locked", int'(locked), 0);
        applyStimulus(1, 61, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        @(posedge clk); #2;
        checkOutput("clr.err_count", int'(err_count), 0);
        checkOutput("clr.fault", int'(fault), 0);

        // Observed counter reset while locked, then a gap.
        for (int i = 72; i <= 76; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 77, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("gap.locked", int'(locked), 0);
        checkOutput("gap.err_count", int'(err_count), 0);

        // Asynchronous reset between clock edges while locked.
        for (int i = 100; i <= 105; i++) applyStimulus(1, i, 0, 0, 0);
        applyStimulus(1, 106, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        valid_in = 1'b0;
        clr_err = 1'b0;
        #1;
        checkZeroOutputs("async");
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 200; i <= 206; i++) applyStimulus(1, i, 0, 0, 0);

        // Randomized counter stream.
        cnt = 250;
        md = 0;
        burst = 0;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 99) < 6) md = ~md;
            r = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 2);
            q = cnt;
            if (burst == 0 && $urandom_range(0, 99) < 2) burst = 3;
            if (burst > 0) begin
                q = $urandom_range(0, QMOD - 1);
                burst--;
            end else if ($urandom_range(0, 99) < 5) begin
                q = $urandom_range(0, QMOD - 1);
            end
            applyStimulus(v, q, md, r, c);
            if (v) cnt = r ? 0 : (md ? (cnt + QMOD - 1) % QMOD : (cnt + 1) % QMOD);
        end

        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("drain.pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
